// File: rtl/cam_cfg_pkg.sv
// Shared types and widths for the camera register-configuration sequencer.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_REQ   = 3'd1,
    ST_GAP   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } cfg_state_t;

  // ROM entry layout: {addr[15:8], data[7:0]}
  localparam int CFG_W = 16;
  localparam int CNT_W = 16;

endpackage

// File: rtl/cam_cfg_ctrl_if.sv
// SCCB write handshake between the configuration sequencer and the SCCB master.
interface cam_cfg_ctrl_if;

  logic       sccb_req;
  logic [7:0] sccb_addr;
  logic [7:0] sccb_data;
  logic       sccb_ack;
  logic       sccb_nack;

  modport master (
    output sccb_req, sccb_addr, sccb_data,
    input  sccb_ack, sccb_nack
  );

  modport slave (
    input  sccb_req, sccb_addr, sccb_data,
    output sccb_ack, sccb_nack
  );

endinterface

// File: rtl/cam_cfg_rom.sv
// Sensor register list; the only place the register values are kept.
module cam_cfg_rom
  import cam_cfg_pkg::*;
(
  input  logic [7:0]       idx,
  output logic [CFG_W-1:0] entry
);

  always_comb begin
    entry = '0;
    case (idx)
      8'd0:    entry = 16'h1280;
      8'd1:    entry = 16'h1101;
      8'd2:    entry = 16'h3A04;
      8'd3:    entry = 16'h40D0;
      8'd4:    entry = 16'h1438;
      8'd5:    entry = 16'h4F80;
      8'd6:    entry = 16'h5080;
      8'd7:    entry = 16'h5100;
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/cam_cfg_ctrl.sv
// Camera configuration sequencer: power-up wait, then one SCCB write per ROM
// entry with NACK retries; cfg_done enables the receive datapath.
module cam_cfg_ctrl
  import cam_cfg_pkg::*;
#(
  parameter int REG_NUM   = 8,
  parameter int PWRUP_DLY = 1000,
  parameter int WR_GAP    = 50,
  parameter int RETRY_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  cam_cfg_ctrl_if.master        sccb,
  output logic [7:0]            cfg_idx,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_DLY - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(WR_GAP - 1);
  localparam logic [7:0]       IDX_LAST   = 8'(REG_NUM - 1);
  localparam logic [3:0]       RETRY_LIM  = 4'(RETRY_MAX);

  cfg_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       idx, idx_n;
  logic [3:0]       retry, retry_n;
  logic             req_n, done_n, err_n;
  logic [7:0]       addr_n, data_n;
  logic [CFG_W-1:0] entry;

  cam_cfg_rom u_rom (
    .idx   (idx),
    .entry (entry)
  );

  assign cfg_idx = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_PWRUP;
      cnt            <= '0;
      idx            <= '0;
      retry          <= '0;
      sccb.sccb_req  <= 1'b0;
      sccb.sccb_addr <= '0;
      sccb.sccb_data <= '0;
      cfg_done       <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      idx            <= idx_n;
      retry          <= retry_n;
      sccb.sccb_req  <= req_n;
      sccb.sccb_addr <= addr_n;
      sccb.sccb_data <= data_n;
      cfg_done       <= done_n;
      cfg_err        <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    retry_n = retry;
    req_n   = sccb.sccb_req;
    addr_n  = sccb.sccb_addr;
    data_n  = sccb.sccb_data;
    done_n  = cfg_done;
    err_n   = cfg_err;
    case (state)
      ST_PWRUP: begin
        if (cnt == PWRUP_LAST) begin
          state_n = ST_REQ;
          cnt_n   = '0;
          idx_n   = '0;
          req_n   = 1'b1;
          addr_n  = entry[15:8];
          data_n  = entry[7:0];
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_REQ: begin
        if (sccb.sccb_ack) begin
          req_n = 1'b0;
          if (!sccb.sccb_nack) begin
            retry_n = '0;
            if (idx == IDX_LAST) begin
              state_n = ST_DONE;
              done_n  = 1'b1;
            end else begin
              idx_n   = idx + 8'd1;
              state_n = ST_GAP;
              cnt_n   = '0;
            end
          end else begin
            // retry_n counts attempts made so far on this entry
            retry_n = retry + 4'd1;
            if (retry_n == RETRY_LIM) begin
              state_n = ST_ERR;
              err_n   = 1'b1;
              done_n  = 1'b0;
            end else begin
              state_n = ST_GAP;
              cnt_n   = '0;
            end
          end
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = ST_REQ;
          cnt_n   = '0;
          req_n   = 1'b1;
          addr_n  = entry[15:8];
          data_n  = entry[7:0];
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_DONE, ST_ERR: begin
        // Re-run skips the power-up wait and enters through a normal gap
        if (start) begin
          state_n = ST_GAP;
          cnt_n   = '0;
          idx_n   = '0;
          retry_n = '0;
          done_n  = 1'b0;
          err_n   = 1'b0;
        end
      end
      default: state_n = ST_PWRUP;
    endcase
  end

endmodule

// File: doc/cam_cfg_ctrl.md
Name: cam_cfg_ctrl

Overview:
Camera register-configuration sequencer for the CMOS capture path.
- After reset it waits out the sensor power-up time, then walks a register table and issues one SCCB write per entry to an external SCCB master through a req/ack handshake.
- It retries NACKed writes and raises cfg_done when the whole table is written. cfg_done is the signal that enables the camera receive datapath.
- It raises cfg_err if an entry exhausts its retries.

Parameters:
- REG_NUM, 8: number of table entries written (1..256).
- PWRUP_DLY, 1000: clk cycles waited after reset before the first write (1..65535).
- WR_GAP, 50: idle clk cycles between consecutive transactions, retries included (1..65535).
- RETRY_MAX, 3: total attempts per entry before an error (1..15).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; re-runs configuration from DONE or ERR.
- sccb_req  out  1  write request to the SCCB master.
- sccb_addr  out  8  register address for the current entry.
- sccb_data  out  8  register value for the current entry.
- sccb_ack  in  1  single-cycle pulse: transaction finished.
- sccb_nack  in  1  qualifies sccb_ack: the device did not acknowledge.
- cfg_idx  out  8  index of the current table entry.
- cfg_done  out  1  configuration complete (level).
- cfg_err  out  1  configuration aborted (level).

Behaviour:
- Reset (async assert, sync release):
  - state=PWRUP; counters, idx and retry count = 0.
  - sccb_req=0, sccb_addr=0, sccb_data=0, cfg_idx=0, cfg_done=0, cfg_err=0.
- States: PWRUP, REQ, GAP, DONE, ERR. All outputs are registered.
- PWRUP:
  - 16-bit counter counts up.
  - At count==PWRUP_DLY-1, go to REQ with idx=0.
- REQ:
  - sccb_req=1 from the first cycle in REQ; sccb_addr/sccb_data = rom[idx], held stable while sccb_req=1.
  - The state holds until sccb_ack=1 is sampled.
  - On ack with nack=0: retry=0. If idx==REG_NUM-1, go to DONE; otherwise idx+1 and go to GAP.
  - On ack with nack=1: retry+1. If the new retry==RETRY_MAX, go to ERR; otherwise go to GAP with idx unchanged.
  - sccb_req=0 in the cycle after the ack is sampled.
- GAP:
  - Counter counts up; at count==WR_GAP-1, go to REQ.
- DONE: cfg_done=1, sccb_req=0.
- ERR: cfg_err=1, cfg_done=0, sccb_req=0; cfg_idx holds the failing entry.
- start in DONE or ERR:
  - Next cycle cfg_done=0, cfg_err=0, idx=0, retry=0, state=GAP. The power-up delay is not repeated.
- start in PWRUP, REQ or GAP: ignored.
- sccb_ack outside REQ: ignored.
- sccb_nack without sccb_ack: ignored.
- start and ack in the same cycle: the ack is processed; start is ignored unless the state is already DONE or ERR.
- cfg_idx = idx; widths are never exceeded because idx < REG_NUM ≤ 256.
- rst_n low mid-transaction: sccb_req drops immediately; after release the sequence restarts from PWRUP.

Decomposition:
- cam_cfg_pkg holds:
  - the state enum encoding (3 bits);
  - the ROM entry width constant CFG_W=16 ({addr[15:8], data[7:0]});
  - the counter width CNT_W=16.
- Sub-module cam_cfg_rom: combinational case table, input idx[7:0], output entry[15:0]. Out-of-range index returns 16'h0000. The sensor register list lives only in this sub-module.

Test Plan:
(All scenarios use REG_NUM=4, PWRUP_DLY=10, WR_GAP=3, RETRY_MAX=2; ROM = {12'h80,11'h01,3A'h04,40'hD0}.)
1. Release rst_n; SCCB model acks 5 cycles after each req -> first sccb_req rises 10 cycles after release; 4 writes issued, in table order, with matching addr/data; ≥3 idle cycles between writes; cfg_done=1 the cycle after the 4th ack.
2. NACK on the first attempt of idx=1 -> 11/01 re-issued after a 3-cycle gap; second attempt acked; idx advances; cfg_done=1, cfg_err=0 at the end.
3. NACK on both attempts of idx=2 -> cfg_err=1, cfg_idx=2, cfg_done=0; sccb_req stays 0 afterwards.
4. From ERR, pulse start -> cfg_err=0 next cycle; first req (addr 12, data 80) after 3 cycles; full table completes; cfg_done=1.
5. Assert rst_n low while sccb_req=1 on idx=2 -> sccb_req=0 and cfg_idx=0 immediately; after release the first req comes 10 cycles later with idx=0.
6. Spurious sccb_ack during GAP and a start pulse during REQ -> no idx change, no retry increment, no restart; the sequence matches scenario 1.
